// File: rtl/gpu_decode_stage.sv
// Registered decode stage: splits instruction fields, classifies them, and issues one per cycle on valid/ready.
// Define DECODE_SCOREBOARD_EN to stall issue on RAW/WAW hazards against a pending-register vector.
module gpu_decode_stage #(
   parameter int INSTR_W    = 32,
   parameter int OP_W       = 4,
   parameter int DT_W       = 4,
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSTR_W-1:0]    in_instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OP_W-1:0]       out_opcode,
   output logic [DT_W-1:0]       out_dtype,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [REG_ADDR_W-1:0] out_rs1,
   output logic [REG_ADDR_W-1:0] out_rs2,
   output logic                  out_is_ld,
   output logic                  out_is_st,
   output logic                  out_is_halt,
   output logic                  out_reg_write,
   input  logic                  wb_valid,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  flush,
   output logic                  halted,
   output logic [CNT_W-1:0]      issued_count
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam int DT_LSB   = INSTR_W - OP_W - DT_W;
   localparam int RD_LSB   = DT_LSB - REG_ADDR_W;
   localparam int RS1_LSB  = RD_LSB - REG_ADDR_W;
   localparam int RS2_LSB  = RS1_LSB - REG_ADDR_W;

   typedef enum logic {RUN, HALTED} stateT;

   typedef struct packed {
      logic [OP_W-1:0]       opcode;
      logic [DT_W-1:0]       dtype;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  isLd;
      logic                  isSt;
      logic                  isHalt;
      logic                  regWrite;
   } payloadT;

   stateT           state_q, state_d;
   payloadT         payload_q, payload_d, decPayload;
   logic            outValid_q, outValid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic            hazard;
   logic            accept;
   logic            unusedInstrBits;

   always_comb begin
      decPayload.opcode   = in_instr[INSTR_W-1 -: OP_W];
      decPayload.dtype    = in_instr[DT_LSB  +: DT_W];
      decPayload.rd       = in_instr[RD_LSB  +: REG_ADDR_W];
      decPayload.rs1      = in_instr[RS1_LSB +: REG_ADDR_W];
      decPayload.rs2      = in_instr[RS2_LSB +: REG_ADDR_W];
      decPayload.isLd     = (decPayload.opcode == OP_W'(5));
      decPayload.isSt     = (decPayload.opcode == OP_W'(6));
      decPayload.isHalt   = &decPayload.opcode;
      decPayload.regWrite = ~decPayload.isSt & ~decPayload.isHalt;
   end

   // Bits below rs2 carry no decoded meaning.
   assign unusedInstrBits = ^in_instr;

   assign in_ready = ~halted & ~flush & ~hazard & (~outValid_q | out_ready);
   assign accept   = in_valid & in_ready;

`ifdef DECODE_SCOREBOARD_EN
   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [NUM_REGS-1:0] wbMask, setMask, effPending;

   // Writeback retiring this cycle is bypassed so a dependent can issue alongside it.
   assign wbMask     = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
   assign effPending = pending_q & ~wbMask;
   assign setMask    = (accept & decPayload.regWrite) ? (NUM_REGS'(1) << decPayload.rd) : '0;
   assign hazard     = effPending[decPayload.rs1] | effPending[decPayload.rs2] |
                       (decPayload.regWrite & effPending[decPayload.rd]);
   assign pending_d  = flush ? '0 : (effPending | setMask);

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end
`else
   logic unusedWb;

   assign hazard   = 1'b0;
   assign unusedWb = ^{wb_valid, wb_rd};
`endif

   always_comb begin
      outValid_d = outValid_q;
      payload_d  = payload_q;
      count_d    = count_q;
      if (flush) begin
         outValid_d = 1'b0;
      end else if (accept) begin
         outValid_d = 1'b1;
         payload_d  = decPayload;
         if (~&count_q) count_d = count_q + CNT_W'(1);
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         payload_q  <= '0;
         count_q    <= '0;
      end else begin
         outValid_q <= outValid_d;
         payload_q  <= payload_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Once a halt is issued the stage stays frozen until reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (accept && decPayload.isHalt) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      halted = (state_q == HALTED);
   end

   assign out_valid     = outValid_q;
   assign out_opcode    = payload_q.opcode;
   assign out_dtype     = payload_q.dtype;
   assign out_rd        = payload_q.rd;
   assign out_rs1       = payload_q.rs1;
   assign out_rs2       = payload_q.rs2;
   assign out_is_ld     = payload_q.isLd;
   assign out_is_st     = payload_q.isSt;
   assign out_is_halt   = payload_q.isHalt;
   assign out_reg_write = payload_q.regWrite;
   assign issued_count  = count_q;

endmodule
